branch_redirect_ctrl: RTL and testbench

Sequences front-end recovery after a control-flow redirect. Accepts the branch unit's mispredict pulse and corrected target, plus a trap request, and arbitrates them into one redirect. It drives a timed pipeline flush, a valid/ready redirect handshake to fetch, and an issue stall until the first refilled instruction arrives. It sits between the exec stage (branch unit, exception logic) and fetch/decode.

---
 rtl/branch_redirect_ctrl.sv | 154 +++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: arbitrates branch-mispredict and trap redirects into a
// single front-end recovery sequence: a timed pipeline flush, a valid/ready
// redirect handshake to fetch, then an issue stall until the first refilled
// instruction arrives.
//
// Optional feature macro: BRANCH_REDIRECT_STATS_EN adds saturating counters of
// accepted mispredicts, accepted traps and issue-stall cycles.
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned ALEN         = 32
`ifdef BRANCH_REDIRECT_STATS_EN
  , parameter int unsigned STAT_WIDTH = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mispredict_valid,
  input  logic [ALEN-1:0] mispredict_target,
  input  logic            trap_valid,
  input  logic [ALEN-1:0] trap_target,
  input  logic            fetch_ready,
  input  logic            refill_valid,
  output logic            flush_pipeline,
  output logic            redirect_valid,
  output logic [ALEN-1:0] redirect_addr,
  output logic            issue_stall,
  output logic            busy
`ifdef BRANCH_REDIRECT_STATS_EN
  , output logic [STAT_WIDTH-1:0] stat_mispredicts
  , output logic [STAT_WIDTH-1:0] stat_traps
  , output logic [STAT_WIDTH-1:0] stat_stall_cycles
`endif
);

  // Flush counter counts down to zero; FLUSH_CYCLES is at most 15.
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT,
    S_REFILL
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [ALEN-1:0] addr_q, addr_d;
  logic            flush_q, redirect_valid_q, issue_stall_q, busy_q;
  logic            mispredict_take;

  // Next-state logic: a trap is accepted in every state and always restarts the
  // flush; a mispredict is only accepted from IDLE, since any in-flight flush
  // has already squashed its source.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    mispredict_take = 1'b0;
    if (trap_valid) begin
      state_d = S_FLUSH;
      cnt_d   = CNT_LOAD;
      addr_d  = trap_target;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mispredict_valid) begin
            state_d         = S_FLUSH;
            cnt_d           = CNT_LOAD;
            addr_d          = mispredict_target;
            mispredict_take = 1'b1;
          end
        end
        S_FLUSH: begin
          if (cnt_q == 4'd0) begin
            state_d = S_REDIRECT;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_REDIRECT: begin
          if (redirect_valid_q && fetch_ready) begin
            state_d = S_REFILL;
          end
        end
        S_REFILL: begin
          if (refill_valid) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, counter, target and outputs registered together; outputs are
  // decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= 4'd0;
      addr_q           <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      issue_stall_q    <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      addr_q           <= addr_d;
      flush_q          <= (state_d == S_FLUSH);
      redirect_valid_q <= (state_d == S_REDIRECT);
      issue_stall_q    <= (state_d != S_IDLE);
      busy_q           <= (state_d != S_IDLE);
    end
  end

  assign flush_pipeline = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_addr  = addr_q;
  assign issue_stall    = issue_stall_q;
  assign busy           = busy_q;

`ifdef BRANCH_REDIRECT_STATS_EN
  logic [STAT_WIDTH-1:0] stat_mis_q, stat_trap_q, stat_stall_q;

  // Saturating event and stall-cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_mis_q   <= '0;
      stat_trap_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (mispredict_take && (stat_mis_q != '1)) begin
        stat_mis_q <= stat_mis_q + STAT_WIDTH'(1);
      end
      if (trap_valid && (stat_trap_q != '1)) begin
        stat_trap_q <= stat_trap_q + STAT_WIDTH'(1);
      end
      if (issue_stall_q && (stat_stall_q != '1)) begin
        stat_stall_q <= stat_stall_q + STAT_WIDTH'(1);
      end
    end
  end

  assign stat_mispredicts  = stat_mis_q;
  assign stat_traps        = stat_trap_q;
  assign stat_stall_cycles = stat_stall_q;
`else
  // Only consumed by the statistics counters.
  logic unused_take;
  assign unused_take = mispredict_take;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Testbench for branch_redirect_ctrl: directed recovery scenarios followed by
// randomized traffic, all checked every cycle against a timestamp-based model
// (time of last accepted event, handshake seen, recovery active).
module tb_branch_redirect_ctrl;

  localparam int FC = 2;
  localparam int AL = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mispredict_valid = 1'b0;
  logic [AL-1:0] mispredict_target = '0;
  logic          trap_valid = 1'b0;
  logic [AL-1:0] trap_target = '0;
  logic          fetch_ready = 1'b0;
  logic          refill_valid = 1'b0;
  logic          flush_pipeline;
  logic          redirect_valid;
  logic [AL-1:0] redirect_addr;
  logic          issue_stall;
  logic          busy;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0]   stat_mispredicts, stat_traps, stat_stall_cycles;
`endif

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .FLUSH_CYCLES(FC),
    .ALEN        (AL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mispredict_valid (mispredict_valid),
    .mispredict_target(mispredict_target),
    .trap_valid       (trap_valid),
    .trap_target      (trap_target),
    .fetch_ready      (fetch_ready),
    .refill_valid     (refill_valid),
    .flush_pipeline   (flush_pipeline),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .issue_stall      (issue_stall),
    .busy             (busy)
`ifdef BRANCH_REDIRECT_STATS_EN
    , .stat_mispredicts (stat_mispredicts)
    , .stat_traps       (stat_traps)
    , .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: recovery is a timeline anchored at the cycle of the last
  // accepted event. Flush covers the FC cycles after it, the redirect is
  // offered from then until a handshake, then refill waits for refill_valid.
  bit          m_active = 1'b0;
  bit          m_hs     = 1'b0;
  int          m_ev     = 0;
  int          m_cyc    = 0;
  logic [AL-1:0] m_addr = '0;
  int          m_st_mis = 0, m_st_trap = 0, m_st_stall = 0;

  function automatic bit exp_flush();
    return m_active && !m_hs && (m_cyc <= m_ev + FC);
  endfunction

  function automatic bit exp_redirect();
    return m_active && !m_hs && (m_cyc > m_ev + FC);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, m_cyc, got, exp);
    end
  endtask

  // One clock: check outputs of the current cycle, apply new inputs, advance
  // the model by the inputs that the next edge samples.
  task automatic drive(input bit r, input bit m, input logic [AL-1:0] mt,
                       input bit t, input logic [AL-1:0] tt, input bit fr, input bit rv);
    @(negedge clk);
    check_eq("flush_pipeline", flush_pipeline, exp_flush());
    check_eq("redirect_valid", redirect_valid, exp_redirect());
    check_eq("redirect_addr", redirect_addr, m_addr);
    check_eq("issue_stall", issue_stall, m_active);
    check_eq("busy", busy, m_active);
`ifdef BRANCH_REDIRECT_STATS_EN
    check_eq("stat_mispredicts", stat_mispredicts, m_st_mis);
    check_eq("stat_traps", stat_traps, m_st_trap);
    check_eq("stat_stall_cycles", stat_stall_cycles, m_st_stall);
`endif
    rst = r; mispredict_valid = m; mispredict_target = mt;
    trap_valid = t; trap_target = tt; fetch_ready = fr; refill_valid = rv;
    if (r) begin
      m_active = 1'b0; m_hs = 1'b0; m_addr = '0;
      m_st_mis = 0; m_st_trap = 0; m_st_stall = 0;
    end else begin
      if (m_active) m_st_stall++;
      if (t) begin
        m_st_trap++;
        m_active = 1'b1; m_hs = 1'b0; m_ev = m_cyc; m_addr = tt;
        $display("[TB] cycle %0d trap accepted, target %h", m_cyc, tt);
      end else if (!m_active && m) begin
        m_st_mis++;
        m_active = 1'b1; m_hs = 1'b0; m_ev = m_cyc; m_addr = mt;
        $display("[TB] cycle %0d mispredict accepted, target %h", m_cyc, mt);
      end else if (exp_redirect() && fr) begin
        m_hs = 1'b1;
        $display("[TB] cycle %0d redirect handshake, addr %h", m_cyc, m_addr);
      end else if (m_active && m_hs && rv) begin
        m_active = 1'b0;
        $display("[TB] cycle %0d refill done", m_cyc);
      end
    end
    m_cyc++;
  endtask

  task automatic idle(input int n, input bit fr, input bit rv);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0, fr, rv);
  endtask

  initial begin
    // Reset and reset-state checks
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b1);

    // Basic mispredict: immediate handshake, refill one cycle after it
    drive(1'b0, 1'b1, 32'h8000_0100, 1'b0, '0, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b1);
    idle(2, 1'b0, 1'b0);

    // Simultaneous trap and mispredict: trap wins
    drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);

    // fetch_ready held low in REDIRECT
    drive(1'b0, 1'b1, 32'h0000_4440, 1'b0, '0, 1'b0, 1'b0);
    idle(7, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b1);

    // Trap in the second flush cycle of a mispredict
    drive(1'b0, 1'b1, 32'h200, 1'b0, '0, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 32'h300, 1'b1, 1'b0);
    idle(4, 1'b1, 1'b1);

    // Mispredict pulses during FLUSH and REFILL are ignored
    drive(1'b0, 1'b1, 32'h500, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h600, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h700, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h800, 1'b0, '0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b0);

    // Trap in REDIRECT on the handshake cycle, then trap in REFILL
    drive(1'b0, 1'b1, 32'h900, 1'b0, '0, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 32'ha00, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 32'hb00, 1'b0, 1'b0);
    idle(4, 1'b1, 1'b1);

    // Reset asserted in REDIRECT; later refill_valid has no effect
    drive(1'b0, 1'b1, 32'hc00, 1'b0, '0, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 4) == 0), $urandom(),
            ($urandom_range(0, 19) == 0), $urandom(),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 1) == 1));
    end
    idle(1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
